policy_check_pipe: RTL and testbench
====================================

POLICY_CHECK_PIPE -- requirements
Module: policy_check_pipe

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
 - NUM_MEM_REGIONS, 4, runtime-programmable region slots (1..16).
 - NUM_DOMAINS, 4, runtime-programmable domain slots (1..16).
 - ID_WIDTH, 16, transaction ID width.
 - ADDR_WIDTH, 32, address width.
 - CNT_WIDTH, 16, violation counter width.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
 - ACLK, in, 1, single clock; all state on rising edge.
 - ARESETN, in, 1, reset, asynchronous, active-low.
 - CFG_WE, in, 1, table write strobe.
 - CFG_TARGET, in, 1, 0 = region slot, 1 = domain slot.
 - CFG_IDX, in, 4, slot index; writes to slots at or above the count are ignored.
 - CFG_EN, in, 1, slot enable written with the entry.
 - CFG_VALUE, in, ADDR_WIDTH, region base, or domain ID in bits [ID_WIDTH-1:0].
 - CFG_MASK, in, ADDR_WIDTH, region significant-bit mask, or domain ID mask in bits [ID_WIDTH-1:0].
 - POLICY, in, NUM_MEM_REGIONS x NUM_DOMAINS pu_pkg::policy_entry_t, read/write permission per (region, domain).
 - REQ_VALID / REQ_READY, in / out, 1 each, request handshake.
 - REQ_ID, in, ID_WIDTH, transaction ID.
 - REQ_ADDR, in, ADDR_WIDTH, transaction address.
 - REQ_LEN, in, axi_pkg::len_t, burst length.
 - REQ_SIZE, in, axi_pkg::size_t, beat size.
 - REQ_WRITE, in, 1, 0 = read, 1 = write.
 - RSP_VALID / RSP_READY, out / in, 1 each, response handshake.
 - RSP_GRANTED, out, 1, decision; valid only while RSP_VALID=1.
 - VIOL_VALID, out, 1, sticky first-violation flag; also the interrupt line.
 - VIOL_ID, out, ID_WIDTH, ID of the first denied request.
 - VIOL_ADDR, out, ADDR_WIDTH, address of the first denied request.
 - VIOL_WRITE, out, 1, direction of the first denied request.
 - VIOL_CNT, out, CNT_WIDTH, denied-response count.
 - VIOL_CLR, in, 1, clears the violation record.

Function
REQ-003 Handshake: transfer only on VALID&&READY; RSP_VALID and response payload SHALL hold stable until RSP_READY.
REQ-004 Pipeline of 2 stages: S1 registers the request; S1->S2 evaluates matches; S2 drives the response.
REQ-005 Latency SHALL be exactly 2 cycles from request acceptance to RSP_VALID with no backpressure; throughput SHALL be 1 request per cycle.
REQ-006 Stall rules: S2 ready = !S2_valid || RSP_READY; REQ_READY = !S1_valid || S2 ready; no combinational path from REQ_VALID to REQ_READY.
REQ-007 Last byte address: last = REQ_ADDR + ((REQ_LEN+1) << REQ_SIZE) - 1, computed in ADDR_WIDTH+1 bits.
REQ-008 Address wrap: a carry out of bit ADDR_WIDTH-1 SHALL force the request to be denied.
REQ-009 A region SHALL match when all of the following hold: it is enabled; (ADDR & MASK) == (BASE & MASK); (last & MASK) == (ADDR & MASK). An enabled region with MASK=0 matches every address.
REQ-010 A domain SHALL match when it is enabled and (REQ_ID & MASK) == (ID & MASK).
REQ-011 Grant: granted=1 iff some (region i, domain j) pair both match and POLICY[i][j].read (read) or .write (write) is set; otherwise deny (default deny).
REQ-012 Config writes SHALL take effect from the cycle after CFG_WE. An evaluation in the same cycle SHALL use the pre-write table.
REQ-013 Violation record: on each response handshake with RSP_GRANTED=0:
 - VIOL_CNT increments and saturates at all-ones.
 - If VIOL_VALID=0, VIOL_ID, VIOL_ADDR and VIOL_WRITE capture the request and VIOL_VALID is set.
 - The captured fields SHALL hold while VIOL_VALID=1.
REQ-014 VIOL_CLR alone SHALL zero VIOL_CNT and VIOL_VALID next cycle.
REQ-015 VIOL_CLR coinciding with a denied response SHALL produce VIOL_CNT=1, with the new request captured and VIOL_VALID=1.
REQ-016 The block SHALL contain no combinational path from POLICY to RSP_GRANTED without a register stage.

Reset
REQ-017 ARESETN low SHALL immediately clear all of the following:
 - all region and domain slots (enable=0, value=0, mask=0);
 - S1 and S2 valid bits; RSP_VALID=0, RSP_GRANTED=0;
 - VIOL_VALID=0, VIOL_CNT=0, VIOL_ID=0, VIOL_ADDR=0, VIOL_WRITE=0.
REQ-018 During reset REQ_READY=0. REQ_READY SHALL be 1 the first cycle after deassertion. In-flight requests SHALL be dropped without a response.

Verification
REQ-019 The bench SHALL cover these scenarios:
 - Region 0 = base 0x4000_0000, mask 0xFFF0_0000; domain 0 = ID 0x0010, mask 0xFFF0; POLICY[0][0] = read only. Read, ID 0x0013, ADDR 0x4000_1000, LEN 3, SIZE 2 -> granted=1 two cycles later. The same request as a write -> granted=0, VIOL_VALID=1, VIOL_CNT=1.
 - Read at ADDR 0x400F_FFF0, LEN 7, SIZE 2 (last byte 0x4010_000F crosses the region) -> granted=0.
 - Read at ADDR 0xFFFF_FFF0, LEN 15, SIZE 3, region with mask 0 -> wrap detected, granted=0.
 - Stream of 8 back-to-back requests with RSP_READY toggling 1/0 -> responses in order, none lost or duplicated, no payload change while stalled.
 - Two denials (ID 0x0020, then ID 0x0030) -> VIOL_ID=0x0020, VIOL_CNT=2. VIOL_CLR coinciding with a third denial (ID 0x0040) -> VIOL_CNT=1, VIOL_ID=0x0040.
 - ARESETN pulsed low with two requests in flight -> no responses. After release, a request with an empty table -> granted=0.

Source files
------------

// File: rtl/policy_check_pipe.sv
// Two-stage access-policy checker: S1 registers the request and its last byte address,
// S2 registers the region/domain/policy decision and keeps a sticky first-violation record.
package axi_pkg;
  typedef logic [7:0] len_t;
  typedef logic [2:0] size_t;
endpackage

package pu_pkg;
  typedef struct packed {
    logic read;
    logic write;
  } policy_entry_t;
endpackage

module policy_check_pipe #(
  parameter int unsigned NUM_MEM_REGIONS = 4,
  parameter int unsigned NUM_DOMAINS     = 4,
  parameter int unsigned ID_WIDTH        = 16,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  CFG_WE,
  input  logic                  CFG_TARGET,
  input  logic [3:0]            CFG_IDX,
  input  logic                  CFG_EN,
  input  logic [ADDR_WIDTH-1:0] CFG_VALUE,
  input  logic [ADDR_WIDTH-1:0] CFG_MASK,
  input  pu_pkg::policy_entry_t [NUM_MEM_REGIONS-1:0][NUM_DOMAINS-1:0] POLICY,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic [ID_WIDTH-1:0]   REQ_ID,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  axi_pkg::len_t         REQ_LEN,
  input  axi_pkg::size_t        REQ_SIZE,
  input  logic                  REQ_WRITE,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic                  RSP_GRANTED,
  output logic                  VIOL_VALID,
  output logic [ID_WIDTH-1:0]   VIOL_ID,
  output logic [ADDR_WIDTH-1:0] VIOL_ADDR,
  output logic                  VIOL_WRITE,
  output logic [CNT_WIDTH-1:0]  VIOL_CNT,
  input  logic                  VIOL_CLR
);

  localparam int unsigned AW1 = ADDR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [NUM_MEM_REGIONS-1:0] r_rgn_en;
  logic [ADDR_WIDTH-1:0]      r_rgn_base [NUM_MEM_REGIONS];
  logic [ADDR_WIDTH-1:0]      r_rgn_mask [NUM_MEM_REGIONS];
  logic [NUM_DOMAINS-1:0]     r_dom_en;
  logic [ID_WIDTH-1:0]        r_dom_id   [NUM_DOMAINS];
  logic [ID_WIDTH-1:0]        r_dom_mask [NUM_DOMAINS];

  logic                  r_s1_valid, r_s1_write;
  logic [ID_WIDTH-1:0]   r_s1_id;
  logic [ADDR_WIDTH-1:0] r_s1_addr;
  logic [ADDR_WIDTH:0]   r_s1_last;

  logic                  r_s2_valid, r_s2_granted, r_s2_write;
  logic [ID_WIDTH-1:0]   r_s2_id;
  logic [ADDR_WIDTH-1:0] r_s2_addr;

  logic                  r_viol_valid, r_viol_write;
  logic [ID_WIDTH-1:0]   r_viol_id;
  logic [ADDR_WIDTH-1:0] r_viol_addr;
  logic [CNT_WIDTH-1:0]  r_viol_cnt;

  logic                       w_s2_ready, w_req_ready, w_grant, w_deny_hs;
  logic [ADDR_WIDTH:0]        w_bytes, w_last;
  logic [NUM_MEM_REGIONS-1:0] w_rgn_hit;
  logic [NUM_DOMAINS-1:0]     w_dom_hit;

  // Slot indices at or above the slot count never match a loop index, so they are dropped.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rgn_en <= '0;
      r_dom_en <= '0;
      for (int i = 0; i < NUM_MEM_REGIONS; i++) begin
        r_rgn_base[i] <= '0;
        r_rgn_mask[i] <= '0;
      end
      for (int j = 0; j < NUM_DOMAINS; j++) begin
        r_dom_id[j]   <= '0;
        r_dom_mask[j] <= '0;
      end
    end else if (CFG_WE) begin
      for (int i = 0; i < NUM_MEM_REGIONS; i++) begin
        if (!CFG_TARGET && CFG_IDX == 4'(i)) begin
          r_rgn_en[i]   <= CFG_EN;
          r_rgn_base[i] <= CFG_VALUE;
          r_rgn_mask[i] <= CFG_MASK;
        end
      end
      for (int j = 0; j < NUM_DOMAINS; j++) begin
        if (CFG_TARGET && CFG_IDX == 4'(j)) begin
          r_dom_en[j]   <= CFG_EN;
          r_dom_id[j]   <= CFG_VALUE[ID_WIDTH-1:0];
          r_dom_mask[j] <= CFG_MASK[ID_WIDTH-1:0];
        end
      end
    end
  end

  // Extra top bit of the last-byte address carries the wrap indication.
  always_comb begin
    w_bytes = (AW1'(REQ_LEN) + AW1'(1)) << REQ_SIZE;
    w_last  = AW1'(REQ_ADDR) + w_bytes - AW1'(1);
  end

  always_comb begin
    w_rgn_hit = '0;
    w_dom_hit = '0;
    w_grant   = 1'b0;
    for (int i = 0; i < NUM_MEM_REGIONS; i++) begin
      w_rgn_hit[i] = r_rgn_en[i]
          && ((r_s1_addr & r_rgn_mask[i]) == (r_rgn_base[i] & r_rgn_mask[i]))
          && ((r_s1_last[ADDR_WIDTH-1:0] & r_rgn_mask[i]) == (r_s1_addr & r_rgn_mask[i]));
    end
    for (int j = 0; j < NUM_DOMAINS; j++) begin
      w_dom_hit[j] = r_dom_en[j]
          && ((r_s1_id & r_dom_mask[j]) == (r_dom_id[j] & r_dom_mask[j]));
    end
    for (int i = 0; i < NUM_MEM_REGIONS; i++) begin
      for (int j = 0; j < NUM_DOMAINS; j++) begin
        if (w_rgn_hit[i] && w_dom_hit[j]
            && (r_s1_write ? POLICY[i][j].write : POLICY[i][j].read)) begin
          w_grant = 1'b1;
        end
      end
    end
    if (r_s1_last[ADDR_WIDTH]) w_grant = 1'b0;
  end

  assign w_s2_ready  = !r_s2_valid || RSP_READY;
  // Gating with the reset keeps the request side closed while reset is held.
  assign w_req_ready = ARESETN && (!r_s1_valid || w_s2_ready);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_s1_valid   <= 1'b0;
      r_s1_write   <= 1'b0;
      r_s1_id      <= '0;
      r_s1_addr    <= '0;
      r_s1_last    <= '0;
      r_s2_valid   <= 1'b0;
      r_s2_granted <= 1'b0;
      r_s2_write   <= 1'b0;
      r_s2_id      <= '0;
      r_s2_addr    <= '0;
    end else begin
      if (w_req_ready) begin
        r_s1_valid <= REQ_VALID;
        if (REQ_VALID) begin
          r_s1_write <= REQ_WRITE;
          r_s1_id    <= REQ_ID;
          r_s1_addr  <= REQ_ADDR;
          r_s1_last  <= w_last;
        end
      end
      if (w_s2_ready) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_granted <= w_grant;
          r_s2_write   <= r_s1_write;
          r_s2_id      <= r_s1_id;
          r_s2_addr    <= r_s1_addr;
        end
      end
    end
  end

  assign w_deny_hs = r_s2_valid && RSP_READY && !r_s2_granted;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_viol_valid <= 1'b0;
      r_viol_write <= 1'b0;
      r_viol_id    <= '0;
      r_viol_addr  <= '0;
      r_viol_cnt   <= '0;
    end else if (VIOL_CLR) begin
      r_viol_valid <= w_deny_hs;
      r_viol_cnt   <= w_deny_hs ? CNT_ONE : '0;
      if (w_deny_hs) begin
        r_viol_id    <= r_s2_id;
        r_viol_addr  <= r_s2_addr;
        r_viol_write <= r_s2_write;
      end
    end else if (w_deny_hs) begin
      if (r_viol_cnt != '1) r_viol_cnt <= r_viol_cnt + CNT_ONE;
      if (!r_viol_valid) begin
        r_viol_valid <= 1'b1;
        r_viol_id    <= r_s2_id;
        r_viol_addr  <= r_s2_addr;
        r_viol_write <= r_s2_write;
      end
    end
  end

  assign REQ_READY   = w_req_ready;
  assign RSP_VALID   = r_s2_valid;
  assign RSP_GRANTED = r_s2_granted;
  assign VIOL_VALID  = r_viol_valid;
  assign VIOL_ID     = r_viol_id;
  assign VIOL_ADDR   = r_viol_addr;
  assign VIOL_WRITE  = r_viol_write;
  assign VIOL_CNT    = r_viol_cnt;

endmodule

// File: tb/tb_policy_check_pipe.sv
// Directed bench for policy_check_pipe: hand-computed decisions, violation record,
// stall behaviour and reset flush.
module tb_policy_check_pipe;

  logic        ACLK, ARESETN;
  logic        CFG_WE, CFG_TARGET, CFG_EN;
  logic [3:0]  CFG_IDX;
  logic [31:0] CFG_VALUE, CFG_MASK;
  pu_pkg::policy_entry_t [3:0][3:0] POLICY;
  logic        REQ_VALID, REQ_READY, REQ_WRITE;
  logic [15:0] REQ_ID;
  logic [31:0] REQ_ADDR;
  axi_pkg::len_t  REQ_LEN;
  axi_pkg::size_t REQ_SIZE;
  logic        RSP_VALID, RSP_READY, RSP_GRANTED;
  logic        VIOL_VALID, VIOL_WRITE, VIOL_CLR;
  logic [15:0] VIOL_ID, VIOL_CNT;
  logic [31:0] VIOL_ADDR;

  int n_vec = 0;
  int n_err = 0;

  policy_check_pipe dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .CFG_WE(CFG_WE), .CFG_TARGET(CFG_TARGET), .CFG_IDX(CFG_IDX), .CFG_EN(CFG_EN),
    .CFG_VALUE(CFG_VALUE), .CFG_MASK(CFG_MASK), .POLICY(POLICY),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ID(REQ_ID), .REQ_ADDR(REQ_ADDR),
    .REQ_LEN(REQ_LEN), .REQ_SIZE(REQ_SIZE), .REQ_WRITE(REQ_WRITE),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_GRANTED(RSP_GRANTED),
    .VIOL_VALID(VIOL_VALID), .VIOL_ID(VIOL_ID), .VIOL_ADDR(VIOL_ADDR),
    .VIOL_WRITE(VIOL_WRITE), .VIOL_CNT(VIOL_CNT), .VIOL_CLR(VIOL_CLR)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, observed no finish, required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic cfg_write(input logic tgt, input logic [3:0] idx, input logic en,
                           input logic [31:0] val, input logic [31:0] msk);
    CFG_TARGET = tgt; CFG_IDX = idx; CFG_EN = en; CFG_VALUE = val; CFG_MASK = msk;
    CFG_WE = 1'b1;
    tick();
    CFG_WE = 1'b0;
  endtask

  task automatic drive(input logic [15:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic wr);
    REQ_VALID = 1'b1; REQ_ID = id; REQ_ADDR = addr; REQ_LEN = len; REQ_SIZE = size;
    REQ_WRITE = wr;
  endtask

  // Single request with RSP_READY held high; clr is asserted on the handshake cycle.
  task automatic do_req(input string tag, input logic [15:0] id, input logic [31:0] addr,
                        input logic [7:0] len, input logic [2:0] size, input logic wr,
                        input logic exp_g, input logic clr);
    drive(id, addr, len, size, wr);
    tick();
    REQ_VALID = 1'b0;
    check({tag, "_lat1"}, RSP_VALID, 1'b0);
    tick();
    check({tag, "_lat2"}, RSP_VALID, 1'b1);
    check({tag, "_grant"}, RSP_GRANTED, exp_g);
    VIOL_CLR = clr;
    tick();
    VIOL_CLR = 1'b0;
    check({tag, "_done"}, RSP_VALID, 1'b0);
  endtask

  initial begin
    logic [7:0] pat;
    int sent, rcv;
    logic prev_stall, prev_g;

    ARESETN = 1'b0; CFG_WE = 1'b0; CFG_TARGET = 1'b0; CFG_IDX = '0; CFG_EN = 1'b0;
    CFG_VALUE = '0; CFG_MASK = '0; POLICY = '0; REQ_VALID = 1'b0; REQ_ID = '0;
    REQ_ADDR = '0; REQ_LEN = '0; REQ_SIZE = '0; REQ_WRITE = 1'b0; RSP_READY = 1'b1;
    VIOL_CLR = 1'b0;

    repeat (2) tick();
    check("rst_req_ready", REQ_READY, 1'b0);
    check("rst_rsp_valid", RSP_VALID, 1'b0);
    check("rst_viol_valid", VIOL_VALID, 1'b0);
    check("rst_viol_cnt", VIOL_CNT, 16'h0);
    ARESETN = 1'b1;
    #1;
    check("rel_req_ready", REQ_READY, 1'b1);
    tick();

    cfg_write(1'b0, 4'd0, 1'b1, 32'h4000_0000, 32'hFFF0_0000);
    cfg_write(1'b1, 4'd0, 1'b1, 32'h0000_0010, 32'h0000_FFF0);
    POLICY[0][0].read = 1'b1;

    do_req("rd_ok", 16'h0013, 32'h4000_1000, 8'd3, 3'd2, 1'b0, 1'b1, 1'b0);
    check("rd_ok_noviol", VIOL_VALID, 1'b0);
    do_req("wr_deny", 16'h0013, 32'h4000_1000, 8'd3, 3'd2, 1'b1, 1'b0, 1'b0);
    check("wr_viol_valid", VIOL_VALID, 1'b1);
    check("wr_viol_cnt", VIOL_CNT, 16'd1);
    check("wr_viol_id", VIOL_ID, 16'h0013);
    check("wr_viol_addr", VIOL_ADDR, 32'h4000_1000);
    check("wr_viol_write", VIOL_WRITE, 1'b1);

    // Last byte 0x4010_000F leaves the 1 MiB region.
    do_req("cross", 16'h0013, 32'h400F_FFF0, 8'd7, 3'd2, 1'b0, 1'b0, 1'b0);
    check("cross_cnt", VIOL_CNT, 16'd2);
    check("cross_hold_addr", VIOL_ADDR, 32'h4000_1000);
    check("cross_hold_write", VIOL_WRITE, 1'b1);

    VIOL_CLR = 1'b1;
    tick();
    VIOL_CLR = 1'b0;
    check("clr_cnt", VIOL_CNT, 16'd0);
    check("clr_valid", VIOL_VALID, 1'b0);

    cfg_write(1'b0, 4'd1, 1'b1, 32'h0, 32'h0);
    POLICY[1][0].read = 1'b1;
    POLICY[1][1].read = 1'b1;
    do_req("mask0", 16'h0010, 32'h1234_5678, 8'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    do_req("top_nowrap", 16'h0013, 32'hFFFF_FFF0, 8'd3, 3'd2, 1'b0, 1'b1, 1'b0);
    do_req("wrap", 16'h0013, 32'hFFFF_FFF0, 8'd15, 3'd3, 1'b0, 1'b0, 1'b0);
    check("wrap_cnt", VIOL_CNT, 16'd1);
    check("wrap_addr", VIOL_ADDR, 32'hFFFF_FFF0);
    check("wrap_write", VIOL_WRITE, 1'b0);

    // Domain 1 written in the same cycle the request is evaluated: old table applies.
    drive(16'h0050, 32'h0000_1000, 8'd0, 3'd0, 1'b0);
    tick();
    REQ_VALID = 1'b0;
    cfg_write(1'b1, 4'd1, 1'b1, 32'h0000_0050, 32'h0000_FFFF);
    check("cfg_same_valid", RSP_VALID, 1'b1);
    check("cfg_same_grant", RSP_GRANTED, 1'b0);
    tick();
    check("cfg_same_cnt", VIOL_CNT, 16'd2);
    do_req("cfg_after", 16'h0050, 32'h0000_1000, 8'd0, 3'd0, 1'b0, 1'b1, 1'b0);

    VIOL_CLR = 1'b1;
    tick();
    VIOL_CLR = 1'b0;
    do_req("d20", 16'h0020, 32'h4000_1000, 8'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    do_req("d30", 16'h0030, 32'h4000_1000, 8'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    check("d2_id", VIOL_ID, 16'h0020);
    check("d2_cnt", VIOL_CNT, 16'd2);
    do_req("d40", 16'h0040, 32'h4000_1000, 8'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    check("clrdeny_cnt", VIOL_CNT, 16'd1);
    check("clrdeny_id", VIOL_ID, 16'h0040);
    check("clrdeny_valid", VIOL_VALID, 1'b1);

    // Back-to-back stream with RSP_READY toggling; bit k of pat is the decision of request k.
    pat = 8'b0100_1011;
    sent = 0; rcv = 0; prev_stall = 1'b0; prev_g = 1'b0;
    for (int cyc = 0; cyc < 48; cyc++) begin
      RSP_READY = (cyc % 2 == 0);
      if (sent < 8) begin
        drive(pat[sent] ? 16'(16'h0010 | sent) : 16'(16'h0060 | sent),
              32'h4000_0000 + 32'(sent) * 32'h100, 8'd0, 3'd0, 1'b0);
      end else begin
        REQ_VALID = 1'b0;
      end
      @(negedge ACLK);
      if (prev_stall) begin
        check("stream_hold_valid", RSP_VALID, 1'b1);
        check("stream_hold_grant", RSP_GRANTED, prev_g);
      end
      if (RSP_VALID && RSP_READY) begin
        if (rcv < 8) check("stream_order", RSP_GRANTED, pat[rcv]);
        rcv++;
      end
      prev_stall = RSP_VALID && !RSP_READY;
      prev_g     = RSP_GRANTED;
      if (REQ_VALID && REQ_READY) sent++;
      tick();
    end
    REQ_VALID = 1'b0;
    RSP_READY = 1'b1;
    check("stream_sent", 32'(sent), 32'd8);
    check("stream_rcvd", 32'(rcv), 32'd8);

    // Reset with two requests in flight.
    drive(16'h0013, 32'h4000_1000, 8'd0, 3'd0, 1'b0);
    tick();
    drive(16'h0013, 32'h4000_2000, 8'd0, 3'd0, 1'b0);
    tick();
    REQ_VALID = 1'b0;
    check("flight_valid", RSP_VALID, 1'b1);
    ARESETN = 1'b0;
    #1;
    check("flush_rsp_valid", RSP_VALID, 1'b0);
    check("flush_req_ready", REQ_READY, 1'b0);
    check("flush_viol_valid", VIOL_VALID, 1'b0);
    tick();
    tick();
    ARESETN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("flush_no_rsp", RSP_VALID, 1'b0);
    end
    do_req("empty_tbl", 16'h0013, 32'h4000_1000, 8'd3, 3'd2, 1'b0, 1'b0, 1'b0);
    check("empty_cnt", VIOL_CNT, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
